// File: rtl/wb_cfg_pkg.sv
// Shared types and constants for the Wishbone configuration initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wb_cfg_pkg;

  localparam int WB_DW   = 32;
  localparam int WB_AW   = 32;
  localparam int WB_SELW = 4;

  // Byte distance between consecutive beats of a burst.
  localparam logic [WB_AW-1:0] ADDR_STRIDE = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WDATA = 3'd1,
    ST_BUS   = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  // Word-align a byte address; the low two bits never reach the bus.
  function automatic logic [WB_AW-1:0] align_adr(input logic [WB_AW-1:0] a);
    return a & ~(WB_AW'(3));
  endfunction

endpackage

// File: rtl/wb_cfg_master_timeout.sv
// Beat watchdog: counts cycles spent waiting for ack and flags the last allowed one.
// Latency: hit asserts combinationally in the MAX-th consecutive run cycle.
// Backpressure: none; holds its count at the hit point until cleared.
module wb_timeout_ctr #(
  parameter int MAX = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic hit
);

  localparam int CW = (MAX < 2) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  // Count consecutive run cycles; any clear (or reset) restarts from zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (run && !hit) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The cycle in which the count shows MAX-1 is the MAX-th cycle of waiting.
  assign hit = run && (cnt == CW'(MAX - 1));

endmodule

// File: rtl/wb_cfg_master.sv
// Wishbone B3 classic initiator: burst commands + write stream in, one bus beat per word, responses out.
// Latency: cmd handshake -> stb next cycle; ack -> rsp_valid next cycle; all outputs registered.
// Backpressure: cmd/wr ready only in their states; rsp held until rsp_ready, bus idle meanwhile. Option: WB_TIMEOUT_EN.
module wb_cfg_master
  import wb_cfg_pkg::*;
#(
  parameter int LEN_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [WB_AW-1:0]   cmd_adr,
  input  logic [WB_SELW-1:0] cmd_sel,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [WB_DW-1:0]   wr_dat,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WB_DW-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [WB_SELW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i
);

  state_t state_q, state_n;

  logic               we_q,   we_n;
  logic [WB_SELW-1:0] sel_q,  sel_n;
  logic [WB_AW-1:0]   adr_q,  adr_n;
  logic [LEN_W-1:0]   len_q,  len_n;
  logic [LEN_W-1:0]   beat_q, beat_n;
  logic [WB_DW-1:0]   wdat_q, wdat_n;
  logic [WB_DW-1:0]   rdat_q, rdat_n;
  logic               err_q,  err_n;
  logic               cyc_q;
  logic               last_beat;
  logic               to_hit;

  assign last_beat = (beat_q == len_q);

`ifdef WB_TIMEOUT_EN
  // Watchdog restarts on every entry to BUS because every beat is preceded by a non-BUS cycle.
  wb_timeout_ctr #(
    .MAX (TIMEOUT_CYC)
  ) u_timeout (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .clr (state_q != ST_BUS),
    .run (state_q == ST_BUS),
    .hit (to_hit)
  );
`else
  assign to_hit = 1'b0;
`endif

  // Next-state and next-datapath decode; everything defaults to holding its value.
  always_comb begin
    state_n = state_q;
    we_n    = we_q;
    sel_n   = sel_q;
    adr_n   = adr_q;
    len_n   = len_q;
    beat_n  = beat_q;
    wdat_n  = wdat_q;
    rdat_n  = rdat_q;
    err_n   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          we_n    = cmd_we;
          adr_n   = align_adr(cmd_adr);
          sel_n   = cmd_sel;
          len_n   = cmd_len;
          beat_n  = '0;
          err_n   = 1'b0;
          state_n = cmd_we ? ST_WDATA : ST_BUS;
        end
      end

      ST_WDATA: begin
        if (wr_valid && wr_ready) begin
          wdat_n  = wr_dat;
          state_n = ST_BUS;
        end
      end

      ST_BUS: begin
        // An ack in the same cycle as the watchdog hit wins.
        if (wbm_ack_i) begin
          if (!we_q) begin
            rdat_n  = wbm_dat_i;
            state_n = ST_RESP;
          end else if (last_beat) begin
            rdat_n  = '0;
            state_n = ST_RESP;
          end else begin
            adr_n   = adr_q + ADDR_STRIDE;
            beat_n  = beat_q + 1'b1;
            state_n = ST_WDATA;
          end
        end else if (to_hit) begin
          rdat_n = '0;
          err_n  = 1'b1;
          // A write with beats left must still swallow their words to keep the wr stream aligned.
          if (we_q && !last_beat) begin
            beat_n  = beat_q + 1'b1;
            state_n = ST_DRAIN;
          end else begin
            state_n = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          if (!we_q && !last_beat && !err_q) begin
            adr_n   = adr_q + ADDR_STRIDE;
            beat_n  = beat_q + 1'b1;
            state_n = ST_BUS;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        if (wr_valid && wr_ready) begin
          if (last_beat) begin
            state_n = ST_RESP;
          end else begin
            beat_n = beat_q + 1'b1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State, datapath and output registers; handshake outputs are decoded from the next state.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      sel_q     <= '0;
      adr_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      wdat_q    <= '0;
      rdat_q    <= '0;
      err_q     <= 1'b0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rsp_valid <= 1'b0;
      cyc_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      we_q      <= we_n;
      sel_q     <= sel_n;
      adr_q     <= adr_n;
      len_q     <= len_n;
      beat_q    <= beat_n;
      wdat_q    <= wdat_n;
      rdat_q    <= rdat_n;
      err_q     <= err_n;
      cmd_ready <= (state_n == ST_IDLE);
      wr_ready  <= (state_n == ST_WDATA) || (state_n == ST_DRAIN);
      rsp_valid <= (state_n == ST_RESP);
      cyc_q     <= (state_n == ST_BUS);
    end
  end

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = wdat_q;
  assign rsp_dat   = rdat_q;

`ifdef WB_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_wb_cfg_master.sv
`timescale 1ns/1ps
module tb_wb_cfg_master;

  localparam int LEN_W = 4;
  localparam int TMO   = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [LEN_W-1:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_dat;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_cfg_master #(.LEN_W(LEN_W), .TIMEOUT_CYC(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  int n_tests = 0;
  int n_fail  = 0;

  beat_t       exp_beats[$];
  logic [31:0] wr_q[$];
  logic [31:0] next_wdat[$];
  logic [31:0] rd_exp[$];
  logic [31:0] rd_override[$];
  logic [31:0] beat_adr_log[$];
  logic [31:0] beat_dat_log[$];
  logic [31:0] rsp_log[$];
  int rsp_pending = 0;
  int stall_cnt   = 0;
  int rsp_hold    = 0;
  int rsp_pct     = 100;
  int ack_dly_fixed = 1;
  bit slave_hold = 0, noise_en = 0, wr_gap_en = 0, mon_quiet = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i); #1;
  endtask

  function automatic int next_dly();
    return (ack_dly_fixed >= 0) ? ack_dly_fixed : int'($urandom_range(0, 3));
  endfunction

  // Wishbone responder: acks after a delay, returns override or random data, optional stray acks when idle.
  initial begin
    int dly;
    logic nack;
    logic [31:0] ndat;
    wbm_ack_i = 1'b0; wbm_dat_i = '0; dly = 0;
    forever begin
      @(negedge wb_clk_i);
      nack = 1'b0; ndat = wbm_dat_i;
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
        if (!wbm_we_o) rd_exp.push_back(wbm_dat_i);
        dly = next_dly();
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (!slave_hold) begin
          if (dly == 0) begin
            nack = 1'b1;
            if (rd_override.size() > 0) ndat = rd_override.pop_front();
            else ndat = $urandom;
          end else begin
            dly--;
          end
        end
      end else begin
        dly = next_dly();
        if (noise_en && $urandom_range(0, 7) == 0) begin
          nack = 1'b1; ndat = $urandom;
        end
      end
      @(posedge wb_clk_i); #1;
      wbm_ack_i = nack; wbm_dat_i = ndat;
    end
  end

  // Write-word source.
  initial begin
    bit hs;
    wr_valid = 1'b0; wr_dat = '0;
    forever begin
      @(negedge wb_clk_i);
      hs = wr_valid && wr_ready;
      @(posedge wb_clk_i); #1;
      if (hs && wr_q.size() > 0) wr_q.delete(0);
      if (wr_q.size() > 0 && (!wr_gap_en || $urandom_range(0, 3) != 0)) begin
        wr_valid = 1'b1; wr_dat = wr_q[0];
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  // Response sink with optional forced stall.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (rsp_valid && rsp_hold > 0) rsp_hold--;
      @(posedge wb_clk_i); #1;
      rsp_ready = (rsp_hold == 0) && (int'($urandom_range(0, 99)) < rsp_pct);
    end
  end

  // Checker: expected beats/responses from the command stream, and cycle rules for what must follow each event.
  initial begin
    bit p_rst = 1, p_cmd = 0, p_ack = 0, p_wr = 0, p_rsp = 0, p_hold = 0, p_wait = 0;
    bit cur_we = 0;
    int left = 0;
    logic [31:0] h_dat, w_adr;
    logic h_err;
    beat_t b;
    forever begin
      @(negedge wb_clk_i);
      if (p_rst) begin
        chk("reset cyc", wbm_cyc_o, 0);
        chk("reset stb", wbm_stb_o, 0);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset wr_ready", wr_ready, 0);
        chk("reset cmd_ready", cmd_ready, 1);
      end else if (!mon_quiet) begin
        if (p_cmd) begin
          chk("cmd_ready drops", cmd_ready, 0);
          if (cur_we) chk("wr_ready after cmd", wr_ready, 1);
          else        chk("stb after cmd", wbm_stb_o, 1);
        end
        if (p_ack) begin
          chk("cyc gap after ack", wbm_cyc_o, 0);
          if (!cur_we || left == 0) chk("rsp after ack", rsp_valid, 1);
          else                      chk("wr_ready after ack", wr_ready, 1);
        end
        if (p_wr) chk("stb after wr word", wbm_stb_o, 1);
        if (p_rsp) begin
          if (!cur_we && left > 0) chk("stb after rsp", wbm_stb_o, 1);
          else                     chk("idle after rsp", cmd_ready, 1);
        end
        if (p_hold) begin
          chk("rsp held valid", rsp_valid, 1);
          chk("rsp held dat", rsp_dat, h_dat);
          chk("rsp held err", rsp_err, h_err);
        end
        if (p_wait) begin
          chk("stb held", wbm_stb_o, 1);
          chk("adr held", wbm_adr_o, w_adr);
        end
      end
      p_rst = 0; p_cmd = 0; p_ack = 0; p_wr = 0; p_rsp = 0; p_hold = 0; p_wait = 0;

      if (wb_rst_i) begin
        p_rst = 1;
        exp_beats.delete(); rd_exp.delete();
        left = 0; rsp_pending = 0;
      end else if (!mon_quiet) begin
        chk("stb==cyc", wbm_stb_o, wbm_cyc_o);
        if (rsp_valid) chk("no bus while rsp", wbm_cyc_o, 0);
        if (cmd_ready) chk("idle quiet", {29'd0, wbm_cyc_o, rsp_valid, wr_ready}, 0);
        if (cmd_valid && cmd_ready) begin
          p_cmd = 1; cur_we = cmd_we; left = int'(cmd_len) + 1;
        end
        if (wr_valid && wr_ready) p_wr = 1;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
          if (exp_beats.size() == 0) begin
            chk("unexpected beat", 1, 0);
          end else begin
            b = exp_beats.pop_front();
            chk("beat adr", wbm_adr_o, b.adr);
            chk("beat we", wbm_we_o, b.we);
            chk("beat sel", wbm_sel_o, b.sel);
            if (b.we) chk("beat wdat", wbm_dat_o, b.dat);
          end
          beat_adr_log.push_back(wbm_adr_o);
          beat_dat_log.push_back(wbm_dat_o);
          left--; p_ack = 1;
        end else if (wbm_cyc_o && wbm_stb_o) begin
          p_wait = 1; w_adr = wbm_adr_o;
        end
        if (rsp_valid && rsp_ready) begin
          if (cur_we) chk("write rsp dat", rsp_dat, 0);
          else if (rd_exp.size() == 0) chk("unexpected read rsp", 1, 0);
          else chk("read rsp dat", rsp_dat, rd_exp.pop_front());
          chk("rsp err", rsp_err, 0);
          rsp_log.push_back(rsp_dat);
          rsp_pending--; p_rsp = 1;
        end else if (rsp_valid) begin
          p_hold = 1; h_dat = rsp_dat; h_err = rsp_err; stall_cnt++;
        end
      end
    end
  end

  task automatic send_cmd(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                          input int len, input bit wait_done);
    beat_t b;
    bit hs;
    for (int i = 0; i <= len; i++) begin
      b.adr = (adr & 32'hFFFF_FFFC) + 32'(4 * i);
      b.we = we; b.sel = sel; b.dat = '0;
      if (we) begin
        b.dat = (next_wdat.size() > 0) ? next_wdat.pop_front() : $urandom;
        wr_q.push_back(b.dat);
      end
      exp_beats.push_back(b);
    end
    rsp_pending += we ? 1 : len + 1;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_sel = sel; cmd_len = LEN_W'(len);
    hs = 0;
    for (int c = 0; c < 200 && !hs; c++) begin
      @(negedge wb_clk_i);
      if (cmd_ready) hs = 1;
    end
    chk("cmd accepted", {31'd0, hs}, 1);
    tick();
    cmd_valid = 1'b0;
    if (wait_done) begin
      for (int c = 0; c < 4000 && rsp_pending != 0; c++) @(negedge wb_clk_i);
      chk("burst completed", rsp_pending, 0);
      tick();
    end
  endtask

  task automatic clear_logs();
    beat_adr_log.delete(); beat_dat_log.delete(); rsp_log.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_sel = '0; cmd_len = '0;
    wb_rst_i = 1'b1;
    repeat (3) tick();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("post-reset cmd_ready", cmd_ready, 1);
    chk("post-reset rsp_dat", rsp_dat, 0);
    chk("post-reset adr", wbm_adr_o, 0);
    tick();

    // Single write.
    clear_logs();
    next_wdat.push_back(32'hDEAD_BEEF);
    send_cmd(1, 32'h3000_0000, 4'hF, 0, 1);
    chk("wr1 beats", beat_adr_log.size(), 1);
    chk("wr1 adr", beat_adr_log[0], 32'h3000_0000);
    chk("wr1 dat", beat_dat_log[0], 32'hDEAD_BEEF);
    chk("wr1 rsp", rsp_log[0], 0);

    // Read burst with known data.
    clear_logs();
    ack_dly_fixed = 0;
    rd_override.push_back(32'h11); rd_override.push_back(32'h22);
    rd_override.push_back(32'h33); rd_override.push_back(32'h44);
    send_cmd(0, 32'h3000_0010, 4'hF, 3, 1);
    chk("rd4 rsps", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rd4 adr", beat_adr_log[i], 32'h3000_0010 + 32'(4 * i));
      chk("rd4 dat", rsp_log[i], 32'(8'h11 * (i + 1)));
    end

    // Response backpressure on the first beat.
    clear_logs();
    stall_cnt = 0; rsp_hold = 10;
    send_cmd(0, 32'h3000_0100, 4'h3, 1, 1);
    chk("bp stall cycles", stall_cnt, 10);
    chk("bp rsps", rsp_log.size(), 2);

    // Address wrap and low-bit masking.
    clear_logs();
    send_cmd(0, 32'hFFFF_FFFC, 4'hF, 1, 1);
    send_cmd(0, 32'h2000_0007, 4'h1, 0, 1);
    chk("wrap adr0", beat_adr_log[0], 32'hFFFF_FFFC);
    chk("wrap adr1", beat_adr_log[1], 32'h0000_0000);
    chk("aligned adr", beat_adr_log[2], 32'h2000_0004);

    // Randomized traffic.
    ack_dly_fixed = -1; noise_en = 1; wr_gap_en = 1; rsp_pct = 70;
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : $urandom;
      send_cmd(1'($urandom_range(0, 1)), a, 4'($urandom),
               ($urandom_range(0, 3) == 0) ? 15 : int'($urandom_range(0, 6)), 1);
    end
    noise_en = 0; wr_gap_en = 0; rsp_pct = 100; ack_dly_fixed = 1;
    repeat (3) tick();

`ifdef WB_TIMEOUT_EN
    begin
      int stb_cnt;
      bit seen, done;
      mon_quiet = 1; slave_hold = 1;
      wr_q.push_back(32'hA0); wr_q.push_back(32'hA1); wr_q.push_back(32'hA2);
      cmd_valid = 1; cmd_we = 1; cmd_adr = 32'h3000_0400; cmd_sel = 4'hF; cmd_len = LEN_W'(2);
      tick();
      cmd_valid = 0;
      stb_cnt = 0; seen = 0; done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge wb_clk_i);
        if (wbm_stb_o) begin stb_cnt++; seen = 1; end
        else if (seen) done = 1;
      end
      chk("timeout stb cycles", stb_cnt, TMO);
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge wb_clk_i);
        if (rsp_valid) done = 1;
      end
      chk("timeout rsp seen", {31'd0, done}, 1);
      chk("timeout rsp err", rsp_err, 1);
      chk("timeout rsp dat", rsp_dat, 0);
      chk("timeout drained", wr_q.size(), 0);
      done = 0;
      for (int c = 0; c < 50 && !done; c++) begin
        @(negedge wb_clk_i);
        if (cmd_ready) done = 1;
      end
      chk("timeout back to idle", {31'd0, done}, 1);
      tick();
      slave_hold = 0; mon_quiet = 0;
    end
`endif

    // Reset in the middle of a read burst, then a normal command.
    begin
      bit up;
      clear_logs();
      slave_hold = 1;
      send_cmd(0, 32'h3000_0040, 4'hF, 3, 0);
      up = 0;
      for (int c = 0; c < 20 && !up; c++) begin
        @(negedge wb_clk_i);
        if (wbm_cyc_o) up = 1;
      end
      chk("stb before reset", {31'd0, up}, 1);
      tick(); tick();
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i = 1'b0;
      slave_hold = 0;
      rd_override.push_back(32'h5A5A_0001);
      tick();
      send_cmd(0, 32'h3000_0080, 4'hF, 0, 1);
      chk("post-reset rsp count", rsp_log.size(), 1);
      chk("post-reset rsp dat", rsp_log[0], 32'h5A5A_0001);
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
